// File: rtl/decode_stage.sv
// Instruction-decode pipeline stage: splits raw words into fields, extends the immediate,
// flags illegal opcodes and holds up to two decoded entries so upstream never stalls on out_ready.
//
//   state      | meaning
//   -----------+--------------------------------------------------
//   OCC_EMPTY  | no entry held, out_valid low, in_ready high
//   OCC_ONE    | head valid, tail free, in_ready high
//   OCC_FULL   | head and tail valid, in_ready low
module decode_stage #(
    parameter int                 IW         = 16,
    parameter int                 OPW        = 4,
    parameter int                 RW         = 3,
    parameter int                 IMMW       = 6,
    parameter int                 DATA_W     = 8,
    parameter logic [2**OPW-1:0]  LEGAL_MASK = '1,
    parameter logic [2**OPW-1:0]  SEXT_MASK  = '0,
    parameter int                 CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IW-1:0]     instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPW-1:0]    opcode,
    output logic [RW-1:0]     rd,
    output logic [RW-1:0]     rs1,
    output logic [RW-1:0]     rs2,
    output logic [DATA_W-1:0] imm,
    output logic              illegal,
    output logic [CNT_W-1:0]  decode_count
);

    typedef struct packed {
        logic [OPW-1:0]    opcode;
        logic [RW-1:0]     rd;
        logic [RW-1:0]     rs1;
        logic [RW-1:0]     rs2;
        logic [DATA_W-1:0] imm;
        logic              illegal;
    } entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    occ_e             occ_q, occ_d;
    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;

    entry_t           dec_w;
    logic [IMMW-1:0]  imm_raw;
    logic             accept;
    logic             xfer;

    assign imm_raw = instr[IMMW-1:0];

    always_comb begin
        dec_w         = '0;
        dec_w.opcode  = instr[IW-1 -: OPW];
        dec_w.rd      = instr[IW-OPW-1 -: RW];
        dec_w.rs1     = instr[IW-OPW-RW-1 -: RW];
        dec_w.rs2     = instr[IW-OPW-2*RW-1 -: RW];
        // the signed cast carries bit IMMW-1 into the upper bits
        if (SEXT_MASK[dec_w.opcode]) begin
            dec_w.imm = DATA_W'($signed(imm_raw));
        end else begin
            dec_w.imm = DATA_W'(imm_raw);
        end
        dec_w.illegal = ~LEGAL_MASK[dec_w.opcode];
    end

    assign out_valid = (occ_q != OCC_EMPTY);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid && in_ready_q;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        dcnt_d = dcnt_q;

        if (xfer) begin
            dcnt_d = dcnt_q + CNT_W'(1);
        end

        // head is never rewritten on flush, so the fields keep their last presented values
        if (flush) begin
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        head_d = dec_w;
                        occ_d  = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && xfer) begin
                        head_d = dec_w;
                    end else if (accept) begin
                        tail_d = dec_w;
                        occ_d  = OCC_FULL;
                    end else if (xfer) begin
                        occ_d  = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (xfer) begin
                        head_d = tail_q;
                        occ_d  = OCC_ONE;
                    end
                end
                default: begin
                    occ_d = OCC_EMPTY;
                end
            endcase
        end

        in_ready_d = (occ_d != OCC_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q      <= OCC_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b1;
            dcnt_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
            dcnt_q     <= dcnt_d;
        end
    end

    assign opcode       = head_q.opcode;
    assign rd           = head_q.rd;
    assign rs1          = head_q.rs1;
    assign rs2          = head_q.rs2;
    assign imm          = head_q.imm;
    assign illegal      = head_q.illegal;
    assign decode_count = dcnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (custom masks with a 4-bit counter, and defaults)
// driven in lockstep and checked every cycle against a queue-based model plus literal expectations.
module tb_decode_stage;

    localparam logic [15:0] LEGAL_A = 16'h7FFF;
    localparam logic [15:0] SEXT_A  = 16'h0004;
    localparam logic [15:0] LEGAL_B = 16'hFFFF;
    localparam logic [15:0] SEXT_B  = 16'h0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] instr = 16'h0;

    logic        a_in_ready, a_out_valid, a_illegal;
    logic [3:0]  a_opcode;
    logic [2:0]  a_rd, a_rs1, a_rs2;
    logic [7:0]  a_imm;
    logic [3:0]  a_count;

    logic        b_in_ready, b_out_valid, b_illegal;
    logic [3:0]  b_opcode;
    logic [2:0]  b_rd, b_rs1, b_rs2;
    logic [7:0]  b_imm;
    logic [15:0] b_count;

    decode_stage #(
        .LEGAL_MASK (LEGAL_A),
        .SEXT_MASK  (SEXT_A),
        .CNT_W      (4)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (a_in_ready),
        .instr        (instr),
        .out_valid    (a_out_valid),
        .out_ready    (out_ready),
        .opcode       (a_opcode),
        .rd           (a_rd),
        .rs1          (a_rs1),
        .rs2          (a_rs2),
        .imm          (a_imm),
        .illegal      (a_illegal),
        .decode_count (a_count)
    );

    decode_stage dut_b (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (b_in_ready),
        .instr        (instr),
        .out_valid    (b_out_valid),
        .out_ready    (out_ready),
        .opcode       (b_opcode),
        .rd           (b_rd),
        .rs1          (b_rs1),
        .rs2          (b_rs2),
        .imm          (b_imm),
        .illegal      (b_illegal),
        .decode_count (b_count)
    );

    typedef struct packed {
        logic [3:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [7:0] imm;
        logic       ill;
    } exp_t;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic exp_t dec(input logic [15:0] w, input logic [15:0] sext,
                                 input logic [15:0] legal);
        exp_t e;
        int   op;
        int   im;
        op    = int'(w) / 4096;
        e.op  = 4'(op);
        e.rd  = 3'(int'(w) / 512);
        e.rs1 = 3'(int'(w) / 64);
        e.rs2 = 3'(int'(w) / 8);
        im    = int'(w) % 64;
        if (sext[op] && im >= 32) im = im + 256 - 64;
        e.imm = 8'(im);
        e.ill = !legal[op];
        return e;
    endfunction

    // model: queue of accepted words, transfer count, and the last entry shown at the head
    logic [15:0] q[$];
    int          cnt_model = 0;
    exp_t        last_a = '0;
    exp_t        last_b = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            cnt_model = 0;
            last_a    = '0;
            last_b    = '0;
        end else begin
            bit acc;
            bit xf;
            acc = in_valid && (q.size() < 2);
            xf  = (q.size() > 0) && out_ready;
            if (xf) begin
                void'(q.pop_front());
                cnt_model++;
            end
            if (flush) q.delete();
            else if (acc) q.push_back(instr);
            if (q.size() > 0) begin
                last_a = dec(q[0], SEXT_A, LEGAL_A);
                last_b = dec(q[0], SEXT_B, LEGAL_B);
            end
        end
    end

    always @(negedge clk) begin
        chk("a.out_valid", 32'(a_out_valid), 32'(q.size() > 0));
        chk("a.in_ready",  32'(a_in_ready),  32'(q.size() < 2));
        chk("a.opcode",    32'(a_opcode),    32'(last_a.op));
        chk("a.rd",        32'(a_rd),        32'(last_a.rd));
        chk("a.rs1",       32'(a_rs1),       32'(last_a.rs1));
        chk("a.rs2",       32'(a_rs2),       32'(last_a.rs2));
        chk("a.imm",       32'(a_imm),       32'(last_a.imm));
        chk("a.illegal",   32'(a_illegal),   32'(last_a.ill));
        chk("a.count",     32'(a_count),     32'(cnt_model % 16));
        chk("b.out_valid", 32'(b_out_valid), 32'(q.size() > 0));
        chk("b.in_ready",  32'(b_in_ready),  32'(q.size() < 2));
        chk("b.opcode",    32'(b_opcode),    32'(last_b.op));
        chk("b.rd",        32'(b_rd),        32'(last_b.rd));
        chk("b.rs1",       32'(b_rs1),       32'(last_b.rs1));
        chk("b.rs2",       32'(b_rs2),       32'(last_b.rs2));
        chk("b.imm",       32'(b_imm),       32'(last_b.imm));
        chk("b.illegal",   32'(b_illegal),   32'(last_b.ill));
        chk("b.count",     32'(b_count),     32'(cnt_model % 65536));
    end

    task automatic step(input bit v, input logic [15:0] w, input bit rdy, input bit fl);
        in_valid  = v;
        instr     = w;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.out_valid", 32'(a_out_valid), 32'h0);
        chk("rst.in_ready",  32'(a_in_ready),  32'h1);
        chk("rst.count",     32'(b_count),     32'h0);
        #1 rst = 1'b0;

        // basic decode, one word per cycle, downstream always ready
        step(1'b1, 16'h1C15, 1'b1, 1'b0);
        chk("t1.out_valid", 32'(a_out_valid), 32'h1);
        chk("t1.opcode",    32'(a_opcode),    32'h1);
        chk("t1.rd",        32'(a_rd),        32'h6);
        chk("t1.rs1",       32'(a_rs1),       32'h0);
        chk("t1.rs2",       32'(a_rs2),       32'h2);
        chk("t1.imm",       32'(b_imm),       32'h15);
        chk("t1.illegal",   32'(b_illegal),   32'h0);
        step(1'b1, 16'h4050, 1'b1, 1'b0);
        chk("t2.count",  32'(b_count),  32'h1);
        chk("t2.opcode", 32'(b_opcode), 32'h4);
        chk("t2.rd",     32'(b_rd),     32'h0);
        chk("t2.rs1",    32'(b_rs1),    32'h1);
        chk("t2.rs2",    32'(b_rs2),    32'h2);
        chk("t2.imm",    32'(b_imm),    32'h10);
        step(1'b1, 16'h203F, 1'b1, 1'b0);
        chk("t3.imm_sext", 32'(a_imm), 32'hFF);
        chk("t3.imm_zext", 32'(b_imm), 32'h3F);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("t4.out_valid", 32'(b_out_valid), 32'h0);
        chk("t4.count",     32'(b_count),     32'h3);
        chk("t4.hold_op",   32'(b_opcode),    32'h2);

        // backpressure: third word held upstream, head stable
        step(1'b1, 16'h1C15, 1'b0, 1'b0);
        step(1'b1, 16'h4050, 1'b0, 1'b0);
        chk("bp.in_ready_full", 32'(a_in_ready), 32'h0);
        step(1'b1, 16'h203F, 1'b0, 1'b0);
        chk("bp.in_ready_held", 32'(a_in_ready), 32'h0);
        chk("bp.head_op",       32'(a_opcode),   32'h1);
        chk("bp.head_imm",      32'(a_imm),      32'h15);
        step(1'b1, 16'h203F, 1'b1, 1'b0);
        chk("bp.second_op", 32'(b_opcode),   32'h4);
        chk("bp.in_ready",  32'(b_in_ready), 32'h1);
        step(1'b1, 16'h203F, 1'b1, 1'b0);
        chk("bp.third_op", 32'(b_opcode), 32'h2);
        chk("bp.count5",   32'(b_count),  32'h5);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("bp.drained", 32'(b_out_valid), 32'h0);
        chk("bp.count6",  32'(b_count),     32'h6);

        // flush with a full buffer and a word offered in the same cycle
        step(1'b1, 16'h1C15, 1'b0, 1'b0);
        step(1'b1, 16'h4050, 1'b0, 1'b0);
        step(1'b1, 16'hF000, 1'b0, 1'b1);
        chk("fl.out_valid", 32'(a_out_valid), 32'h0);
        chk("fl.in_ready",  32'(a_in_ready),  32'h1);
        chk("fl.count",     32'(b_count),     32'h6);
        chk("fl.hold_op",   32'(b_opcode),    32'h1);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("fl.dropped", 32'(b_out_valid), 32'h0);

        // flush coinciding with a transfer: the transfer still counts
        step(1'b1, 16'h1C15, 1'b1, 1'b0);
        step(1'b1, 16'h4050, 1'b1, 1'b1);
        chk("flx.out_valid", 32'(b_out_valid), 32'h0);
        chk("flx.count",     32'(b_count),     32'h7);

        // illegal opcode flows through and is counted
        step(1'b1, 16'hF000, 1'b1, 1'b0);
        chk("ill.a_flag", 32'(a_illegal),   32'h1);
        chk("ill.b_flag", 32'(b_illegal),   32'h0);
        chk("ill.valid",  32'(a_out_valid), 32'h1);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("ill.count_a", 32'(a_count), 32'h8);
        chk("ill.count_b", 32'(b_count), 32'h8);

        // mixed traffic pattern
        for (int i = 0; i < 24; i++) begin
            step(i % 3 != 0, 16'(i * 16'h1357 + 16'h0A2C), i % 4 != 1, i == 13);
        end

        // asynchronous reset mid-stream
        step(1'b1, 16'h1C15, 1'b0, 1'b0);
        step(1'b1, 16'h4050, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst.out_valid", 32'(a_out_valid), 32'h0);
        chk("arst.in_ready",  32'(a_in_ready),  32'h1);
        chk("arst.opcode",    32'(a_opcode),    32'h0);
        chk("arst.rd",        32'(b_rd),        32'h0);
        chk("arst.imm",       32'(b_imm),       32'h0);
        chk("arst.count",     32'(b_count),     32'h0);
        @(negedge clk);
        #1 rst = 1'b0;

        // 17 transfers: 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 16'h1000 + 16'(i), 1'b1, 1'b0);
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("wrap.count_a", 32'(a_count),     32'h1);
        chk("wrap.count_b", 32'(b_count),     32'd17);
        chk("wrap.empty",   32'(a_out_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, parametrised instruction-decode pipeline stage. It sits between fetch and register-read/execute. It accepts raw instruction words over a valid/ready handshake, splits them into opcode, register and immediate fields, and extends the immediate to datapath width per opcode. It flags illegal opcodes and buffers up to two decoded instructions in a skid buffer so upstream is never throttled combinationally by downstream.

Parameters:
IW, 16, instruction width in bits.
OPW, 4, opcode field width.
RW, 3, register-address field width (rd, rs1, rs2).
IMMW, 6, immediate field width; IMMW <= IW-OPW-2*RW.
DATA_W, 8, width of the extended immediate output; DATA_W >= IMMW.
LEGAL_MASK, {2**OPW{1'b1}}, bit n = 1 means opcode n is legal.
SEXT_MASK, {2**OPW{1'b0}}, bit n = 1 means opcode n sign-extends its immediate; 0 means zero-extend.
CNT_W, 16, width of the decoded-instruction counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous; discards all buffered entries
in_valid  in  1  instruction word valid
in_ready  out  1  stage can accept a word
instr  in  IW  raw instruction word
out_valid  out  1  decoded entry valid
out_ready  in  1  downstream accepts entry
opcode  out  OPW  instr[IW-1 -: OPW]
rd  out  RW  instr[IW-OPW-1 -: RW]
rs1  out  RW  instr[IW-OPW-RW-1 -: RW]
rs2  out  RW  instr[IW-OPW-2*RW-1 -: RW]
imm  out  DATA_W  instr[IMMW-1:0] extended per SEXT_MASK[opcode]
illegal  out  1  LEGAL_MASK[opcode]==0 for the presented entry
decode_count  out  CNT_W  number of entries accepted downstream

Behaviour:
- Reset (async, rst=1): both buffer slots empty. out_valid=0, in_ready=1, opcode/rd/rs1/rs2/imm=0, illegal=0, decode_count=0. A reset asserted mid-transfer discards all entries; nothing is output on release until a new accept.
- Decode is combinational on instr, registered on accept. Latency: word accepted at edge N is presented at out_* after edge N (1 cycle).
- Accept: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- Two-slot FIFO: head drives outputs, tail holds the skid entry. in_ready = (occupancy < 2), registered, with no combinational path from out_ready.
- Occupancy transitions:
  - 0 -> 1 on accept.
  - 1 -> 1 on simultaneous accept and transfer; the new entry becomes head.
  - 1 -> 2 on accept without transfer.
  - 2 -> 1 on transfer; the tail moves to head and is accepted-never since in_ready=0.
  - 1 -> 0 on transfer without accept.
- Output data and illegal stay stable while out_valid && !out_ready.
- Fields use fixed slices, MSB-first: opcode, rd, rs1, rs2. imm is the low IMMW bits and may overlap rs2. It is zero-extended or sign-extended from bit IMMW-1 to DATA_W.
- illegal is a flag only. Illegal entries flow through normally and are counted.
- decode_count increments by 1 on each output transfer, wraps from 2**CNT_W-1 to 0, and is not cleared by flush.
- flush: at the edge, occupancy becomes 0 and out_valid=0. An accept in the same cycle is dropped. A transfer in the same cycle still counts. in_ready=1 the next cycle.
- No X propagation: opcode/rd/rs1/rs2/imm/illegal hold their last values when out_valid=0 and must not be consumed.

Test Plan:
- Reset then instr=0x1C15, in_valid=1, out_ready=1 -> one cycle later: out_valid=1, opcode=1, rd=6, rs1=0, rs2=2, imm=0x15, illegal=0; decode_count=1 after the transfer edge.
- instr=0x4050 -> opcode=4, rd=0, rs1=1, rs2=2, imm=0x10.
- SEXT_MASK bit 2 set, instr=0x203F -> imm=0xFF; same word with SEXT_MASK bit 2 clear -> imm=0x3F.
- out_ready=0, push 0x1C15, 0x4050, 0x203F back-to-back -> in_ready drops after the second accept, the third is held upstream, head stays 0x1C15 stable. Then out_ready=1 -> outputs in order 0x1C15, 0x4050, 0x203F with no loss or duplication.
- Buffer full, assert flush for 1 cycle with in_valid=1 -> out_valid=0 next cycle, the flush-cycle word dropped, in_ready=1, decode_count unchanged. Also assert rst mid-stream -> all outputs 0 immediately.
- LEGAL_MASK bit 15 cleared, instr=0xF000 -> illegal=1, entry still delivered and counted. CNT_W=4, 17 transfers -> decode_count=1 (wrap).
